rd_hold_latch: RTL

RD_HOLD_LATCH -- requirements
Module: rd_hold_latch

---
 rtl/slip_bus_pkg.sv | 21 ++
 rtl/strobe_sync.sv | 28 ++
 rtl/rd_hold_latch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/slip_bus_pkg.sv
// Shared FSM state type and idle/reset output levels for the read-hold latch.
package slip_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_e;

  localparam logic IDLE_REQ    = 1'b0;
  localparam logic IDLE_OE     = 1'b0;
  localparam logic IDLE_READYL = 1'b1;
  localparam logic IDLE_ERR    = 1'b0;

  // A fetch is outstanding on the register-file side in these states.
  function automatic logic is_busy(input rd_state_e s);
    return (s == ST_REQ) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for the active-low read strobe, plus the previous
// synchronised value so the caller can detect edges. All flops reset high.
module strobe_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_ni,
  output logic sync_o,
  output logic prev_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= strobe_ni;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign prev_o = prev_q;

endmodule

// File: rtl/rd_hold_latch.sv
// Bus read wait-state controller: fetches a register on a strobe fall, holds
// the data on the bus until the strobe rises. Optional timeout: RD_HOLD_TIMEOUT_EN.
module rd_hold_latch
  import slip_bus_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              MasterClock,
  input  logic              resetL,
  input  logic              rd_strobeL,
  input  logic [ADDR_W-1:0] addr,
  output logic              req,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              ack,
  input  logic [DATA_W-1:0] ack_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  output logic              readyL,
  output logic              err
);

  rd_state_e         state_q, state_d;
  logic              sync_s, prev_s;
  logic [1:0]        live_q, live_d;
  logic              armed_q, armed_d;
  logic              start_w, rise_w, timeout_w;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  strobe_sync u_sync (
    .clk_i     (MasterClock),
    .rst_ni    (resetL),
    .strobe_ni (rd_strobeL),
    .sync_o    (sync_s),
    .prev_o    (prev_s)
  );

  // The synchroniser still shows its reset value for two edges after reset;
  // a start is only armed once a genuine high strobe has been observed.
  assign live_d  = {live_q[0], 1'b1};
  assign armed_d = armed_q | (live_q[1] & sync_s);
  assign start_w = armed_q & prev_s & ~sync_s;
  assign rise_w  = ~prev_s & sync_s;

`ifdef RD_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_w = is_busy(state_q) && !ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d     = is_busy(state_q) ? cnt_q + 1'b1 : '0;
  assign err_d     = timeout_w;

  always_ff @(posedge MasterClock) begin
    if (!resetL) begin
      cnt_q <= '0;
      err_q <= IDLE_ERR;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_w = 1'b0;
  assign err       = IDLE_ERR;
`endif

  always_ff @(posedge MasterClock) begin
    if (!resetL) begin
      state_q    <= ST_IDLE;
      live_q     <= '0;
      armed_q    <= 1'b0;
      req_addr_q <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      armed_q    <= armed_d;
      req_addr_q <= req_addr_d;
      dout_q     <= dout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    dout_d     = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_w) begin
          state_d    = ST_REQ;
          req_addr_d = addr;
        end
      end
      ST_REQ: begin
        // An ack coinciding with the strobe rise belongs to an aborted read.
        if (ack) begin
          if (rise_w) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            dout_d  = ack_data;
          end
        end else if (timeout_w) begin
          state_d = ST_HOLD;
          dout_d  = '1;
        end else if (rise_w) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (sync_s) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (ack || timeout_w) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req     = IDLE_REQ;
    dout_oe = IDLE_OE;
    readyL  = IDLE_READYL;
    if (is_busy(state_q)) req = 1'b1;
    if (state_q == ST_HOLD) begin
      dout_oe = 1'b1;
      readyL  = 1'b0;
    end
  end

  assign req_addr = req_addr_q;
  assign dout     = dout_q;

endmodule
